// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Register-file write-back arbiter (ALU vs LSU) with load-data
//               formatting, r0 suppression and a pending-write scoreboard.
//               Optional macro WB_FORWARD_EN adds a combinational forward port.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic [5:0]        lsu_opcode,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
`ifdef WB_FORWARD_EN
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [31:0]       busy_mask
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [5:0] OP_LBU = 6'd34;
    localparam logic [5:0] OP_LHU = 6'd40;
    localparam logic [5:0] OP_LH  = 6'd42;
    localparam logic [5:0] OP_LWU = 6'd32;

    logic [CNT_W-1:0]  starve_cnt;
    logic              starve_hit;
    logic              alu_gnt;
    logic              lsu_gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;
    logic              win_we;
    logic [DATA_W-1:0] lsu_fmt;
    logic [31:0]       set_vec;
    logic [31:0]       clr_vec;
    logic [31:0]       busy_next;

    always_comb begin
        lsu_fmt = lsu_data;
        case (lsu_opcode)
            OP_LBU:  lsu_fmt = {{(DATA_W-8){1'b0}}, lsu_data[7:0]};
            OP_LHU:  lsu_fmt = {{(DATA_W-16){1'b0}}, lsu_data[15:0]};
            OP_LH:   lsu_fmt = {{(DATA_W-16){lsu_data[15]}}, lsu_data[15:0]};
            OP_LWU:  lsu_fmt = {{(DATA_W-32){1'b0}}, lsu_data[31:0]};
            default: lsu_fmt = lsu_data;
        endcase
    end

    // LSU has priority unless the ALU has been denied STARVE_MAX times in a row.
    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
    assign alu_gnt    = !rst && alu_valid && (!lsu_valid || starve_hit);
    assign lsu_gnt    = !rst && lsu_valid && !alu_gnt;
    assign any_gnt    = alu_gnt || lsu_gnt;
    assign alu_ready  = alu_gnt;
    assign lsu_ready  = lsu_gnt;

    assign win_rd   = alu_gnt ? alu_rd : lsu_rd;
    assign win_data = alu_gnt ? alu_data : lsu_fmt;
    assign win_we   = any_gnt && (win_rd != '0);

`ifdef WB_FORWARD_EN
    assign fwd_valid = win_we;
    assign fwd_addr  = win_rd;
    assign fwd_data  = win_data;
`endif

    // A new issue to the same register outranks the retiring write.
    assign set_vec   = (iss_valid && (iss_rd != '0)) ? (32'd1 << iss_rd) : 32'd0;
    assign clr_vec   = rf_we ? (32'd1 << rf_waddr) : 32'd0;
    assign busy_next = ((busy_mask & ~clr_vec) | set_vec) & ~32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            busy_mask  <= '0;
        end else begin
            if (!alu_valid || alu_gnt) begin
                starve_cnt <= '0;
            end else if (!starve_hit) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
            rf_we <= win_we;
            if (any_gnt) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
            end
            busy_mask <= busy_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed plus random bench for regfile_wb_arbiter with a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DATA_W     = 64;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic [5:0]        lsu_opcode;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [31:0]       busy_mask;
`ifdef WB_FORWARD_EN
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_opcode(lsu_opcode), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WB_FORWARD_EN
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`endif
        .busy_mask(busy_mask)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: last write presented, denial streak, pending set.
    int          m_denials;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    logic [31:0] m_pending;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fmt(input logic [5:0] op, input logic [63:0] d);
        case (op)
            6'd34:   return {56'd0, d[7:0]};
            6'd40:   return {48'd0, d[15:0]};
            6'd42:   return {{48{d[15]}}, d[15:0]};
            6'd32:   return {32'd0, d[31:0]};
            default: return d;
        endcase
    endfunction

    task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                         input logic [5:0] op, input logic iv, input logic [4:0] ird);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; lsu_opcode = op;
        iss_valid = iv; iss_rd = ird;
    endtask

    // One clock: check handshakes mid-cycle, advance the model, check registers after the edge.
    task automatic cycle();
        logic        aw, lw;
        logic [4:0]  rd;
        logic [63:0] wd;
        #1;
        if (rst) begin
            aw = 1'b0;
            lw = 1'b0;
        end else begin
            aw = alu_valid && (!lsu_valid || m_denials == STARVE_MAX);
            lw = lsu_valid && !aw;
        end
        rd = aw ? alu_rd : lsu_rd;
        wd = aw ? alu_data : fmt(lsu_opcode, lsu_data);
        chk("alu_ready", alu_ready, aw);
        chk("lsu_ready", lsu_ready, lw);
`ifdef WB_FORWARD_EN
        chk("fwd_valid", fwd_valid, (aw || lw) && rd != 0);
        if ((aw || lw) && rd != 0) begin
            chk("fwd_addr", fwd_addr, rd);
            chk("fwd_data", fwd_data, wd);
        end
`endif
        if (rst) begin
            m_denials = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_pending = '0;
        end else begin
            if (m_we) m_pending[m_addr] = 1'b0;
            if (iss_valid && iss_rd != 0) m_pending[iss_rd] = 1'b1;
            if (alu_valid && !aw)
                m_denials = (m_denials + 1 > STARVE_MAX) ? STARVE_MAX : m_denials + 1;
            else
                m_denials = 0;
            m_we = (aw || lw) && rd != 0;
            if (aw || lw) begin
                m_addr = rd;
                m_data = wd;
            end
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, m_we);
        chk("rf_waddr", rf_waddr, m_addr);
        chk("rf_wdata", rf_wdata, m_data);
        chk("busy_mask", busy_mask, m_pending);
    endtask

    initial begin
        logic [5:0]  ops [5];
        logic [63:0] load_exp [5];
        logic [5:0]  op_pick [4];
        ops      = '{6'd34, 6'd40, 6'd42, 6'd32, 6'd58};
        load_exp = '{64'h81, 64'h8081, 64'hFFFF_FFFF_FFFF_8081, 64'hFFFF_8081, 64'hFFFF_FFFF_FFFF_8081};
        op_pick  = '{6'd32, 6'd34, 6'd40, 6'd42};
        m_denials = 0; m_we = 0; m_addr = 0; m_data = 0; m_pending = 0;

        rst = 1'b1;
        drive(1, 5'd4, 64'hAAAA, 1, 5'd6, 64'hBBBB, 6'd32, 1, 5'd8);
        cycle();
        cycle();
        chk("reset_rf_we", rf_we, 1'b0);
        chk("reset_busy", busy_mask, 32'd0);

        // ALU only
        rst = 1'b0;
        drive(1, 5'd5, 64'h1234, 0, 5'd0, 64'd0, 6'd0, 0, 5'd0);
        cycle();
        chk("t1_waddr", rf_waddr, 5'd5);
        chk("t1_wdata", rf_wdata, 64'h1234);
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 6'd0, 0, 5'd0);
        cycle();
        chk("t1_we_drop", rf_we, 1'b0);

        // Load formatting
        for (int k = 0; k < 5; k++) begin
            drive(0, 5'd0, 64'd0, 1, 5'd7, 64'hFFFF_FFFF_FFFF_8081, ops[k], 0, 5'd0);
            cycle();
            chk("t2_load_fmt", rf_wdata, load_exp[k]);
        end

        // Contention: LSU, LSU, LSU, ALU, LSU
        for (int k = 0; k < 5; k++) begin
            drive(1, 5'd10, 64'hA1, 1, 5'd11, 64'hB2, 6'd58, 0, 5'd0);
            #1;
            chk("t3_alu_gnt", alu_ready, k == 3);
            cycle();
            chk("t3_waddr", rf_waddr, (k == 3) ? 5'd10 : 5'd11);
        end

        // r0 suppression
        drive(0, 5'd0, 64'd0, 1, 5'd0, 64'h55, 6'd32, 1, 5'd0);
        cycle();
        chk("t4_r0_we", rf_we, 1'b0);
        chk("t4_r0_busy", busy_mask, 32'd0);

        // Scoreboard set / set-beats-clear / clear
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 6'd0, 1, 5'd9);
        cycle();
        drive(1, 5'd9, 64'h99, 0, 5'd0, 64'd0, 6'd0, 0, 5'd0);
        cycle();
        drive(1, 5'd9, 64'h9A, 0, 5'd0, 64'd0, 6'd0, 1, 5'd9);
        cycle();
        chk("t5_set_wins", busy_mask[9], 1'b1);
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 6'd0, 0, 5'd0);
        cycle();
        chk("t5_cleared", busy_mask[9], 1'b0);

        // Reset mid-flight
        drive(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 6'd0, 1, 5'd3);
        cycle();
        drive(1, 5'd3, 64'h33, 1, 5'd12, 64'h44, 6'd58, 0, 5'd0);
        cycle();
        cycle();
        rst = 1'b1;
        drive(1, 5'd3, 64'h33, 0, 5'd0, 64'd0, 6'd0, 1, 5'd4);
        cycle();
        chk("t6_we_after_rst", rf_we, 1'b0);
        chk("t6_busy_after_rst", busy_mask, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1, 5'd13, 64'hC3, 1, 5'd14, 64'hD4, 6'd58, 0, 5'd0);
            cycle();
        end

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                  {$urandom(), $urandom()},
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)),
                  {$urandom(), $urandom()},
                  ($urandom_range(0, 4) == 0) ? 6'($urandom()) : op_pick[$urandom_range(0, 3)],
                  $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
